// File: rtl/raytracing_scheduler.sv
// Frame scheduler for a bank of ray workers: launches one batch of pixels per row slice,
// waits for every worker to run and finish, then drains their color buffers to the framebuffer.
module raytracing_scheduler #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic [N_WORKERS-1:0]                     worker_activate,
  output logic [N_WORKERS*12-1:0]                  worker_pixel_start_x,
  output logic [11:0]                              pixel_y,
  output logic [17:0]                              pixel_y_sqrd,
  input  logic [N_WORKERS-1:0]                     worker_busy,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0] worker_buffer,
  output logic                                     fb_we,
  output logic [18:0]                              fb_addr,
  output logic [11:0]                              fb_data,
  input  logic                                     fb_ready
);
  localparam int BATCH_PIX = N_WORKERS * JOBS_SUBDIVISION;
  localparam int N_BATCH   = SCREEN_W / BATCH_PIX;
  localparam int KW        = (BATCH_PIX > 1) ? $clog2(BATCH_PIX) : 1;
  localparam int BW        = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;
  localparam int RW        = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BATCH_PIX - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_BATCH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ROW_SETUP = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_RUN  = 3'd3,
    WAIT_DONE = 3'd4,
    DRAIN     = 3'd5,
    RELEASE   = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t                state_r, state_s;
  logic [RW-1:0]         row_r, row_s;
  logic [BW-1:0]         batch_r, batch_s;
  logic [KW-1:0]         k_r, k_s;
  logic [N_WORKERS-1:0]  seen_r, seen_s;
  logic [N_WORKERS-1:0]  act_r, act_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic [11:0]           py_r, py_s;
  logic [17:0]           pysq_r, pysq_s;
  logic                  we_r, we_s;
  logic [18:0]           addr_r, addr_s;
  logic [11:0]           data_r, data_s;
  logic signed [11:0]    py_calc_s;
  logic signed [17:0]    sq_calc_s;
  logic [11:0]           sx_base_s;
  logic                  sx_load_s;
  logic [11:0]           sx_next_s [N_WORKERS];
  logic [11:0]           sx_r      [N_WORKERS];
  logic [11:0]           buf_s     [BATCH_PIX];

  function automatic logic [18:0] pix_addr(input logic [RW-1:0] r, input logic [BW-1:0] b,
                                           input logic [KW-1:0] k);
    pix_addr = 19'(r) * 19'(SCREEN_W) + 19'(b) * 19'(BATCH_PIX) + 19'(k);
  endfunction

  // Drain order interleaves workers: entry k comes from worker k%N, slot k/N.
  for (genvar w = 0; w < N_WORKERS; w++) begin : g_w
    for (genvar j = 0; j < JOBS_SUBDIVISION; j++) begin : g_j
      assign buf_s[j * N_WORKERS + w] = worker_buffer[(w * JOBS_SUBDIVISION + j) * 12 +: 12];
    end
    assign sx_next_s[w] = sx_base_s + 12'(w);
    assign worker_pixel_start_x[w * 12 +: 12] = sx_r[w];
  end

  assign sx_base_s = 12'(batch_s) * 12'(BATCH_PIX) - 12'(SCREEN_W / 2);
  assign sx_load_s = (state_s == LAUNCH) && (state_r != LAUNCH);

  // Next-state and next-output computation
  always_comb begin
    state_s   = state_r;
    row_s     = row_r;
    batch_s   = batch_r;
    k_s       = k_r;
    seen_s    = seen_r;
    act_s     = act_r;
    py_s      = py_r;
    pysq_s    = pysq_r;
    we_s      = we_r;
    addr_s    = addr_r;
    data_s    = data_r;
    py_calc_s = 12'(SCREEN_H / 2 - 1) - 12'(row_r);
    sq_calc_s = py_calc_s * py_calc_s;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ROW_SETUP;
          row_s   = {RW{1'b0}};
          batch_s = {BW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      ROW_SETUP: begin
        py_s    = py_calc_s;
        pysq_s  = sq_calc_s;
        act_s   = {N_WORKERS{1'b1}};
        state_s = LAUNCH;
      end
      LAUNCH: begin
        seen_s  = {N_WORKERS{1'b0}};
        state_s = WAIT_RUN;
      end
      WAIT_RUN: begin
        seen_s = seen_r | worker_busy;
        if (&(seen_r | worker_busy)) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_RUN;
        end
      end
      WAIT_DONE: begin
        if (worker_busy == {N_WORKERS{1'b0}}) begin
          state_s = DRAIN;
          k_s     = {KW{1'b0}};
          we_s    = 1'b1;
          addr_s  = pix_addr(row_r, batch_r, {KW{1'b0}});
          data_s  = buf_s[{KW{1'b0}}];
        end else begin
          state_s = WAIT_DONE;
        end
      end
      DRAIN: begin
        if (fb_ready) begin
          if (k_r == K_LAST) begin
            state_s = RELEASE;
            we_s    = 1'b0;
            act_s   = {N_WORKERS{1'b0}};
          end else begin
            k_s    = k_r + 1'b1;
            addr_s = pix_addr(row_r, batch_r, k_r + 1'b1);
            data_s = buf_s[k_r + 1'b1];
          end
        end else begin
          state_s = DRAIN;
        end
      end
      RELEASE: begin
        if (batch_r != B_LAST) begin
          batch_s = batch_r + 1'b1;
          act_s   = {N_WORKERS{1'b1}};
          state_s = LAUNCH;
        end else if (row_r != R_LAST) begin
          row_s   = row_r + 1'b1;
          batch_s = {BW{1'b0}};
          state_s = ROW_SETUP;
        end else begin
          row_s   = {RW{1'b0}};
          batch_s = {BW{1'b0}};
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      row_r   <= {RW{1'b0}};
      batch_r <= {BW{1'b0}};
      k_r     <= {KW{1'b0}};
      seen_r  <= {N_WORKERS{1'b0}};
      act_r   <= {N_WORKERS{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      py_r    <= 12'd0;
      pysq_r  <= 18'd0;
      we_r    <= 1'b0;
      addr_r  <= 19'd0;
      data_r  <= 12'd0;
    end else begin
      state_r <= state_s;
      row_r   <= row_s;
      batch_r <= batch_s;
      k_r     <= k_s;
      seen_r  <= seen_s;
      act_r   <= act_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      py_r    <= py_s;
      pysq_r  <= pysq_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
    end
  end

  // Column origins are latched on the way into LAUNCH and held until the next launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_r <= '{default: 12'd0};
    end else if (sx_load_s) begin
      sx_r <= sx_next_s;
    end else begin
      sx_r <= sx_r;
    end
  end

  assign busy            = busy_r;
  assign frame_done      = done_r;
  assign worker_activate = act_r;
  assign pixel_y         = py_r;
  assign pixel_y_sqrd    = pysq_r;
  assign fb_we           = we_r;
  assign fb_addr         = addr_r;
  assign fb_data         = data_r;

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Scoreboarded bench for raytracing_scheduler on a 64x4 frame with four behavioral workers:
// expected writes and launches are queued at start, a monitor pops and compares them.
module tb_raytracing_scheduler;
  localparam int NW   = 4;
  localparam int NJ   = 8;
  localparam int SW   = 64;
  localparam int SH   = 4;
  localparam int NPIX = SW * SH;
  localparam int NB   = SW / (NW * NJ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  busy;
  logic                  frame_done;
  logic [NW-1:0]         worker_activate;
  logic [NW*12-1:0]      worker_pixel_start_x;
  logic [11:0]           pixel_y;
  logic [17:0]           pixel_y_sqrd;
  logic [NW-1:0]         worker_busy;
  logic [NW*NJ*12-1:0]   worker_buffer;
  logic                  fb_we;
  logic [18:0]           fb_addr;
  logic [11:0]           fb_data;
  logic                  fb_ready;

  typedef struct packed { logic [18:0] addr; logic [11:0] data; } wr_t;
  typedef struct packed { logic [11:0] py; logic [17:0] pysq; logic [NW*12-1:0] sx; } ln_t;

  wr_t exp_wr[$];
  ln_t exp_ln[$];
  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int fd_count = 0;
  int w0_g = 0;
  int f0_g = 0;
  int rise_dly [NW] = '{1, 1, 1, 1};
  int run_len  [NW] = '{3, 3, 3, 3};
  int py_tab   [SH] = '{1, 0, -1, -2};
  int sq_tab   [SH] = '{1, 0, 1, 4};
  int sx_tab   [NB] = '{-32, 0};
  logic [NW-1:0] prev_act = 4'b0000;

  raytracing_scheduler #(
    .N_WORKERS(NW), .JOBS_SUBDIVISION(NJ), .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .worker_activate(worker_activate), .worker_pixel_start_x(worker_pixel_start_x),
    .pixel_y(pixel_y), .pixel_y_sqrd(pixel_y_sqrd), .worker_busy(worker_busy),
    .worker_buffer(worker_buffer), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  // Worker w holds {w, j} in slot j; the busy profile per worker is adjustable per test.
  initial begin
    worker_buffer = '0;
    for (int w = NW - 1; w >= 0; w--)
      for (int j = NJ - 1; j >= 0; j--)
        worker_buffer = {worker_buffer[NW*NJ*12-13:0], 4'(w), 8'(j)};
  end

  for (genvar w = 0; w < NW; w++) begin : g_worker
    logic b;
    assign worker_busy[w] = b;
    initial begin
      b = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (worker_activate[w] === 1'b1) begin
          repeat (rise_dly[w]) begin @(posedge clk); #1; end
          b = 1'b1;
          repeat (run_len[w]) begin @(posedge clk); #1; end
          b = 1'b0;
          while (worker_activate[w] === 1'b1) begin @(posedge clk); #1; end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_frame();
    ln_t l;
    wr_t e;
    for (int r = 0; r < SH; r++)
      for (int b = 0; b < NB; b++) begin
        l.py   = 12'(py_tab[r]);
        l.pysq = 18'(sq_tab[r]);
        l.sx   = '0;
        for (int w = NW - 1; w >= 0; w--) l.sx = {l.sx[NW*12-13:0], 12'(sx_tab[b] + w)};
        exp_ln.push_back(l);
      end
    for (int a = 0; a < NPIX; a++) begin
      e.addr = 19'(a);
      e.data = {4'((a % 32) % NW), 8'((a % 32) / NW)};
      exp_wr.push_back(e);
    end
  endtask

  task automatic begin_frame();
    w0_g = wr_count;
    f0_g = fd_count;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_frame(input string nm);
    int n = 0;
    while (fd_count == f0_g && n < 20000) begin @(negedge clk); n++; end
    if (fd_count == f0_g) begin
      total++; bad++;
      $display("FAIL %s_timeout: no frame_done after %0d cycles", nm, n);
    end
    @(posedge clk); #1;
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_done_low"}, 64'(frame_done), 64'd0);
    chk({nm, "_writes"}, 64'(wr_count - w0_g), 64'(NPIX));
    chk({nm, "_done_pulses"}, 64'(fd_count - f0_g), 64'd1);
    chk({nm, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({nm, "_ln_left"}, 64'(exp_ln.size()), 64'd0);
    exp_wr.delete();
    exp_ln.delete();
  endtask

  task automatic wait_addr(input logic [18:0] a);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk); n++;
      ok = (fb_we === 1'b1 && fb_addr === a);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_addr: addr %0d not presented within %0d cycles", a, n);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_fb_we"}, 64'(fb_we), 64'd0);
    chk({tag, "_activate"}, 64'(worker_activate), 64'd0);
    chk({tag, "_fb_addr"}, 64'(fb_addr), 64'd0);
    chk({tag, "_fb_data"}, 64'(fb_data), 64'd0);
    chk({tag, "_pixel_y"}, 64'(pixel_y), 64'd0);
    chk({tag, "_pixel_y_sqrd"}, 64'(pixel_y_sqrd), 64'd0);
    chk({tag, "_start_x"}, 64'(worker_pixel_start_x), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted write and every rising activate
  initial begin : mon
    wr_t e;
    ln_t l;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (fb_we === 1'b1 && fb_ready === 1'b1) begin
          wr_count++;
          chk("drain_workers_idle", 64'(worker_busy), 64'd0);
          chk("drain_activate", 64'(worker_activate), 64'hF);
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got write at addr %0d, want none", fb_addr);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 64'(fb_addr), 64'(e.addr));
            chk("wr_data", 64'(fb_data), 64'(e.data));
          end
        end
        if (worker_activate !== 4'b0000 && prev_act === 4'b0000) begin
          if (exp_ln.size() == 0) begin
            total++; bad++;
            $display("FAIL ln_unexpected: got activate 0x%0h, want none", worker_activate);
          end else begin
            l = exp_ln.pop_front();
            chk("ln_activate", 64'(worker_activate), 64'hF);
            chk("ln_pixel_y", 64'(pixel_y), 64'(l.py));
            chk("ln_pixel_y_sqrd", 64'(pixel_y_sqrd), 64'(l.pysq));
            chk("ln_start_x", 64'(worker_pixel_start_x), 64'(l.sx));
          end
        end
        if (frame_done === 1'b1) begin
          fd_count++;
          chk("done_after_last_write", 64'(exp_wr.size()), 64'd0);
        end
      end
      prev_act = worker_activate;
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Plain full frame
    begin_frame();
    end_frame("frame_plain");

    // fb_ready stall at k=10 plus start asserted while busy
    begin_frame();
    wait_addr(19'd9);
    @(posedge clk); #1;
    fb_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_we", 64'(fb_we), 64'd1);
      chk("stall_addr", 64'(fb_addr), 64'd10);
      chk("stall_data", 64'(fb_data), 64'h202);
    end
    @(posedge clk); #1;
    fb_ready = 1'b1;
    start = 1'b0;
    end_frame("frame_stall");

    // Worker 2 starts 3 cycles late and finishes last
    rise_dly = '{1, 1, 4, 1};
    run_len  = '{2, 2, 6, 2};
    begin_frame();
    end_frame("frame_slow_w2");
    rise_dly = '{1, 1, 1, 1};
    run_len  = '{3, 3, 3, 3};

    // Reset while draining k=7, then a fresh frame
    begin_frame();
    wait_addr(19'd6);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset("abort");
    chk("abort_wr_left", 64'(exp_wr.size()), 64'(NPIX - 7));
    chk("abort_ln_left", 64'(exp_ln.size()), 64'(SH * NB - 1));
    exp_wr.delete();
    exp_ln.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(fd_count), 64'(f0_g));
    @(posedge clk); #1;
    rst = 1'b0;
    begin_frame();
    end_frame("frame_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
